camera_stream_tx: RTL and testbench
===================================

# camera_stream_tx

Camera-side transmitter for the OV7670-style pixel bus: generates P_CLOCK, VSYNC, HREF and an 8-bit data bus carrying RGB565 frames of WIDTH×HEIGHT pixels, two bytes per pixel. It is the synthesizable counterpart of the downsampler/frame-buffer writer. It drives that capture path on-board or in simulation from deterministic test patterns, so capture, colour detection and edge/line logic can be exercised without a physical camera.

## Interface
- WIDTH, 176: active pixels per line (≤511)
- HEIGHT, 144: active lines per frame (≤511)
- H_BLANK, 16: P_CLOCK periods with HREF low after each active line (≥1)
- VSYNC_LINES, 3: line-times with VSYNC high
- V_BACK, 2: idle line-times between VSYNC fall and first HREF (≥1)
- V_FRONT, 2: idle line-times after last active line
- CLOCK  in  1  system clock (CLOCK_24_PLL on board); P_CLOCK = CLOCK/2
- RESET_N  in  1  asynchronous, active-low reset
- ENABLE  in  1  allow frames to start
- PATTERN  in  2  0 solid, 1 colour bars, 2 red stripes, 3 XY ramp
- COLOR  in  16  RGB565 value for PATTERN 0
- P_CLOCK  out  1  pixel clock, free-running
- VSYNC  out  1  frame sync, active high
- HREF  out  1  line valid, active high
- DATA  out  8  byte bus
- BUSY  out  1  high from VSYNC rise until end of V_FRONT
- FRAME_DONE  out  1  one-CLOCK pulse when last active line's H_BLANK ends

## Operation
- Line-time L = 2·WIDTH + H_BLANK P_CLOCK periods. Frame = (VSYNC_LINES + V_BACK + HEIGHT + V_FRONT)·L.
- States: IDLE → VSYNC (VSYNC=1, HREF=0, VSYNC_LINES·L) → VBACK (all low, V_BACK·L) → ACTIVE (HREF=1, 2·WIDTH periods) ↔ HBLANK (HREF=0, H_BLANK periods) → after line HEIGHT-1's HBLANK → VFRONT (V_FRONT·L) → VSYNC if ENABLE=1, else IDLE.
- IDLE→VSYNC requires ENABLE=1 at an update edge. ENABLE is otherwise ignored: deassertion mid-frame completes the frame.
- PATTERN and COLOR are latched on entering VSYNC. Changes mid-frame take effect next frame.
- Byte order per pixel: first byte = pixel[7:0], second byte = pixel[15:8]. Receiver assembles {second, first}.
- X counter 0..WIDTH-1 increments after each second byte. Y counter 0..HEIGHT-1 increments at HBLANK entry. Both are 9 bits and clear on VSYNC entry.
- Pattern 0: pixel = latched COLOR.
- Pattern 1: bar width BW = WIDTH/8 (integer, elaboration time). A bar counter 0..7 advances every BW pixels and saturates at 7. pixel = {5{b[2]}, 6{b[1]}, 5{b[0]}}, giving 0x0000, 0x001F, 0x07E0, … 0xFFFF.
- Pattern 2: pixel = 0xF800 when Y mod 10 = 0, else 0x0000. The mod-10 counter wraps 9→0 and clears on VSYNC entry.
- Pattern 3: pixel = {X[7:3], Y[7:2], X[4:0]}.
- DATA = 0x00 whenever HREF = 0.

## Timing
- Reset (async, RESET_N low): P_CLOCK, VSYNC, HREF, DATA, BUSY, FRAME_DONE = 0; state IDLE; all counters 0. Reset mid-frame aborts the frame immediately.
- P_CLOCK toggles every CLOCK edge, starting at 0, the first CLOCK edge after RESET_N release.
- Update edge: the CLOCK edge on which P_CLOCK goes 1→0. VSYNC, HREF, DATA and BUSY change only on update edges, so they are stable for one full CLOCK before and after each P_CLOCK rise (receiver sample point).
- Exactly 2·WIDTH P_CLOCK rises per line see HREF=1. The first rise in each line carries the first byte of pixel 0.
- Latency: ENABLE seen at an update edge → VSYNC=1 and BUSY=1 on that same edge.
- FRAME_DONE pulses on the update edge entering VFRONT. BUSY falls on the update edge leaving VFRONT.
- Back-to-back frames with ENABLE held high: VFRONT→VSYNC with no IDLE gap. BUSY stays high.

## Test plan
- Reset: hold RESET_N low mid-ACTIVE → all outputs 0 in the same cycle. Release → P_CLOCK toggles, VSYNC/HREF stay 0 with ENABLE=0.
- Default params, PATTERN 0, COLOR 0xF800, one frame → 144 HREF pulses of 352 rises each; bytes alternate 0x00, 0xF8; VSYNC high 3·368 P_CLOCK periods; FRAME_DONE exactly once.
- PATTERN 1 → line pixel 0 = 0x0000, pixel 22 = 0x001F, pixel 44 = 0x07E0, pixel 175 = 0xFFFF.
- PATTERN 2 → lines 0, 10 and 140 are 0xF800; lines 1 and 9 are 0x0000. PATTERN changed to 0 mid-frame → no change until next VSYNC.
- ENABLE dropped during line 50 → frame completes through V_FRONT, then IDLE; BUSY 0; no further VSYNC.
- Checker on every P_CLOCK rise: DATA, HREF and VSYNC unchanged in the preceding and following CLOCK cycle; DATA = 0x00 whenever HREF = 0.

Source files
------------

// File: rtl/camera_stream_tx.sv
// camera_stream_tx: OV7670-style pixel bus transmitter.
// Emits RGB565 test-pattern frames, two bytes per pixel, P_CLOCK = CLOCK/2.
module camera_stream_tx #(
  parameter int WIDTH       = 176,
  parameter int HEIGHT      = 144,
  parameter int H_BLANK     = 16,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2,
  parameter int V_FRONT     = 2
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic [1:0]  PATTERN,
  input  logic [15:0] COLOR,
  output logic        P_CLOCK,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  DATA,
  output logic        BUSY,
  output logic        FRAME_DONE
);

  localparam int LT  = 2 * WIDTH + H_BLANK;
  localparam int CW  = $clog2(LT + 1);
  localparam int LM1 = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int LMX = (LM1 > V_FRONT) ? LM1 : V_FRONT;
  localparam int LW  = $clog2(LMX + 2);
  localparam int BW  = (WIDTH / 8 < 1) ? 1 : WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
  } state_e;

  state_e state_q, state_d;

  logic          pclk_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lin_q, lin_d;
  logic [8:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [2:0]    bar_q, bar_d;
  logic [8:0]    bpx_q, bpx_d;
  logic [3:0]    m10_q, m10_d;
  logic          last_q, last_d;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   col_q, col_d;
  logic          fd_q, fd_d;

  logic        upd;
  logic        end_line;
  logic        end_act;
  logic        end_hb;
  logic        enter_vs;
  logic [15:0] pix;

  // Update edge is the one on which P_CLOCK falls.
  assign upd      = pclk_q;
  assign end_line = (cnt_q == CW'(LT - 1));
  assign end_act  = (cnt_q == CW'(2 * WIDTH - 1));
  assign end_hb   = (cnt_q == CW'(H_BLANK - 1));
  assign enter_vs = (state_d == S_VSYNC) &&
                    (state_q != S_VSYNC);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
    end else if (upd) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ENABLE) state_d = S_VSYNC;
      end
      S_VSYNC: begin
        if (end_line && lin_q == LW'(VSYNC_LINES - 1))
          state_d = S_VBACK;
      end
      S_VBACK: begin
        if (end_line && lin_q == LW'(V_BACK - 1))
          state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (end_act) state_d = S_HBLANK;
      end
      S_HBLANK: begin
        if (end_hb)
          state_d = last_q ? S_VFRONT : S_ACTIVE;
      end
      S_VFRONT: begin
        if (end_line && lin_q == LW'(V_FRONT - 1))
          state_d = ENABLE ? S_VSYNC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    lin_d  = lin_q;
    x_d    = x_q;
    y_d    = y_q;
    bar_d  = bar_q;
    bpx_d  = bpx_q;
    m10_d  = m10_q;
    last_d = last_q;
    pat_d  = pat_q;
    col_d  = col_q;
    fd_d   = 1'b0;
    if (upd) begin
      if (state_d != state_q) begin
        cnt_d = '0;
        lin_d = '0;
      end else if (state_q == S_IDLE) begin
        cnt_d = '0;
      end else if (end_line) begin
        cnt_d = '0;
        lin_d = lin_q + LW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      // Pixel position advances after the second byte.
      if (state_q == S_ACTIVE && cnt_q[0]) begin
        x_d = (x_q == 9'(WIDTH - 1)) ? 9'd0 : x_q + 9'd1;
        if (bpx_q == 9'(BW - 1)) begin
          bpx_d = '0;
          bar_d = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
        end else begin
          bpx_d = bpx_q + 9'd1;
        end
      end
      if (state_q == S_ACTIVE && state_d == S_HBLANK) begin
        y_d    = (y_q == 9'(HEIGHT - 1)) ? 9'd0 : y_q + 9'd1;
        m10_d  = (m10_q == 4'd9) ? 4'd0 : m10_q + 4'd1;
        last_d = (y_q == 9'(HEIGHT - 1));
        bar_d  = '0;
        bpx_d  = '0;
      end
      if (enter_vs) begin
        pat_d  = PATTERN;
        col_d  = COLOR;
        x_d    = '0;
        y_d    = '0;
        bar_d  = '0;
        bpx_d  = '0;
        m10_d  = '0;
        last_d = 1'b0;
      end
      fd_d = (state_q == S_HBLANK) && (state_d == S_VFRONT);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      pclk_q <= 1'b0;
      cnt_q  <= '0;
      lin_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      bar_q  <= '0;
      bpx_q  <= '0;
      m10_q  <= '0;
      last_q <= 1'b0;
      pat_q  <= '0;
      col_q  <= '0;
      fd_q   <= 1'b0;
    end else begin
      pclk_q <= ~pclk_q;
      cnt_q  <= cnt_d;
      lin_q  <= lin_d;
      x_q    <= x_d;
      y_q    <= y_d;
      bar_q  <= bar_d;
      bpx_q  <= bpx_d;
      m10_q  <= m10_d;
      last_q <= last_d;
      pat_q  <= pat_d;
      col_q  <= col_d;
      fd_q   <= fd_d;
    end
  end

  always_comb begin
    pix        = col_q;
    P_CLOCK    = pclk_q;
    VSYNC      = (state_q == S_VSYNC);
    HREF       = (state_q == S_ACTIVE);
    BUSY       = (state_q != S_IDLE);
    FRAME_DONE = fd_q;
    unique case (pat_q)
      2'd0: pix = col_q;
      2'd1: pix = {{5{bar_q[2]}}, {6{bar_q[1]}}, {5{bar_q[0]}}};
      2'd2: pix = (m10_q == 4'd0) ? 16'hF800 : 16'h0000;
      2'd3: pix = {x_q[7:3], y_q[7:2], x_q[4:0]};
      default: pix = col_q;
    endcase
    DATA = 8'h00;
    if (state_q == S_ACTIVE)
      DATA = cnt_q[0] ? pix[15:8] : pix[7:0];
  end

endmodule

// File: tb/tb_camera_stream_tx.sv
// tb_camera_stream_tx: random-pattern frames checked against
// a behavioural pixel model and frame-timing counters.
module tb_camera_stream_tx;

  localparam int W  = 40;
  localparam int H  = 24;
  localparam int HB = 4;
  localparam int VS = 3;
  localparam int VB = 2;
  localparam int VF = 2;
  localparam int L  = 2 * W + HB;
  localparam int F  = (VS + VB + H + VF) * L;
  localparam int BW = W / 8;

  logic        CLOCK = 1'b0;
  logic        RESET_N;
  logic        ENABLE;
  logic [1:0]  PATTERN;
  logic [15:0] COLOR;
  logic        P_CLOCK;
  logic        VSYNC;
  logic        HREF;
  logic [7:0]  DATA;
  logic        BUSY;
  logic        FRAME_DONE;

  camera_stream_tx #(
    .WIDTH(W), .HEIGHT(H), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE),
    .PATTERN(PATTERN), .COLOR(COLOR), .P_CLOCK(P_CLOCK),
    .VSYNC(VSYNC), .HREF(HREF), .DATA(DATA), .BUSY(BUSY),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLOCK = ~CLOCK;

  int ncheck = 0;
  int npass  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncheck++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_pix(logic [1:0] p,
      logic [15:0] c, int x, int y);
    int b;
    int r;
    b = x / BW;
    if (b > 7) b = 7;
    r = 0;
    case (p)
      2'd0: r = c;
      2'd1: r = ((b & 4) != 0 ? 16'hF800 : 0) |
                ((b & 2) != 0 ? 16'h07E0 : 0) |
                ((b & 1) != 0 ? 16'h001F : 0);
      2'd2: r = (y % 10 == 0) ? 16'hF800 : 0;
      default: r = (((x / 8) % 32) << 11) | (((y / 4) % 64) << 5) | (x % 32);
    endcase
    return r[15:0];
  endfunction

  // Frame monitor: samples on every P_CLOCK rise.
  int nf = 0;
  int cur = 0;
  bit open = 0;
  int c_lines, c_bcount, c_gap, c_total, c_vs;
  int c_badlen, c_badgap, c_badbyte, c_fd, c_fdpos;
  logic [1:0]  c_pat;
  logic [15:0] c_col;
  logic [7:0]  lo;
  logic        vs_p = 0;
  logic        hr_p = 0;
  int fr_lines[16], fr_badlen[16], fr_badgap[16], fr_badbyte[16];
  int fr_vs[16], fr_total[16], fr_fd[16], fr_fdpos[16];
  bit fr_done[16];
  logic [15:0] pix [2][H][W];

  task automatic fin();
    if (cur < 16) begin
      fr_lines[cur]   = c_lines;
      fr_badlen[cur]  = c_badlen;
      fr_badgap[cur]  = c_badgap;
      fr_badbyte[cur] = c_badbyte;
      fr_vs[cur]      = c_vs;
      fr_total[cur]   = c_total;
      fr_fd[cur]      = c_fd;
      fr_fdpos[cur]   = c_fdpos;
      fr_done[cur]    = 1'b1;
    end
  endtask

  always @(negedge CLOCK) begin
    int xx;
    int yy;
    int eg;
    logic [15:0] ep;
    logic [7:0]  eb;
    if (!RESET_N) begin
      open = 0;
      vs_p = 0;
      hr_p = 0;
    end else begin
      if (FRAME_DONE && open) begin
        c_fd++;
        c_fdpos = c_total;
      end
      if (P_CLOCK) begin
        if (open && !BUSY) begin
          fin();
          open = 0;
        end
        if (VSYNC && !vs_p) begin
          if (open) fin();
          cur = nf;
          nf++;
          open = 1;
          c_lines = 0; c_bcount = 0; c_gap = 0; c_total = 0; c_vs = 0;
          c_badlen = 0; c_badgap = 0; c_badbyte = 0; c_fd = 0; c_fdpos = 0;
          c_pat = PATTERN;
          c_col = COLOR;
        end
        if (open) begin
          c_total++;
          if (VSYNC) c_vs++;
          if (HREF) begin
            if (!hr_p) begin
              eg = (c_lines == 0) ? VB * L : HB;
              if (c_gap != eg) c_badgap++;
              c_bcount = 0;
            end
            xx = c_bcount / 2;
            yy = c_lines;
            ep = ref_pix(c_pat, c_col, xx, yy);
            eb = (c_bcount % 2 == 1) ? ep[15:8] : ep[7:0];
            if (DATA !== eb) c_badbyte++;
            if (c_bcount % 2 == 0) lo = DATA;
            else if (xx < W && yy < H) pix[cur % 2][yy][xx] = {DATA, lo};
            c_bcount++;
            c_gap = 0;
          end else begin
            if (hr_p) begin
              if (c_bcount != 2 * W) c_badlen++;
              c_lines++;
            end
            if (!VSYNC) c_gap++;
          end
        end
        vs_p = VSYNC;
        hr_p = HREF;
      end
    end
  end

  // Output stability around P_CLOCK rises; DATA idle when HREF low.
  int unstable = 0;
  int dz = 0;
  logic [11:0] prev_o = '0;
  always @(negedge CLOCK) begin
    logic [11:0] cur_o;
    if (!RESET_N) begin
      prev_o = '0;
    end else begin
      cur_o = {VSYNC, HREF, DATA, BUSY};
      if (P_CLOCK && cur_o != prev_o) unstable++;
      if (!HREF && DATA != 8'h00) dz++;
      prev_o = cur_o;
    end
  end

  task automatic start_frame(input logic [1:0] p, input logic [15:0] c,
                             input bit hold);
    @(negedge CLOCK);
    for (int i = 0; i < 4 && !P_CLOCK; i++) @(negedge CLOCK);
    PATTERN = p;
    COLOR   = c;
    ENABLE  = 1'b1;
    @(posedge CLOCK);
    #1;
    chk("vsync_latency", VSYNC, 1);
    chk("busy_latency", BUSY, 1);
    @(negedge CLOCK);
    if (!hold) ENABLE = 1'b0;
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 4 * F && !fr_done[k]; i++) @(negedge CLOCK);
    chk($sformatf("f%0d_end", k), fr_done[k], 1);
  endtask

  task automatic check_frame(input int k);
    chk($sformatf("f%0d_lines", k), fr_lines[k], H);
    chk($sformatf("f%0d_linelen", k), fr_badlen[k], 0);
    chk($sformatf("f%0d_blank", k), fr_badgap[k], 0);
    chk($sformatf("f%0d_bytes", k), fr_badbyte[k], 0);
    chk($sformatf("f%0d_vsync", k), fr_vs[k], VS * L);
    chk($sformatf("f%0d_len", k), fr_total[k], F);
    chk($sformatf("f%0d_done_cnt", k), fr_fd[k], 1);
    chk($sformatf("f%0d_done_pos", k), fr_fdpos[k], (VS + VB + H) * L);
  endtask

  task automatic check_release(input string tag);
    int tog;
    logic pv;
    logic hi;
    tog = 0;
    hi  = 1'b0;
    pv  = P_CLOCK;
    repeat (10) begin
      @(negedge CLOCK);
      if (P_CLOCK != pv) tog++;
      pv = P_CLOCK;
      hi = hi | VSYNC | HREF | BUSY;
    end
    chk({tag, "_pclk_toggle"}, tog, 10);
    chk({tag, "_idle_quiet"}, hi, 0);
  endtask

  initial begin
    logic [15:0] c;
    logic [1:0]  p;
    RESET_N = 1'b0;
    ENABLE  = 1'b0;
    PATTERN = 2'd0;
    COLOR   = 16'h0000;
    repeat (3) @(negedge CLOCK);
    chk("reset_outputs", {P_CLOCK, VSYNC, HREF, DATA, BUSY, FRAME_DONE}, 0);
    RESET_N = 1'b1;
    check_release("rel");

    start_frame(2'd0, 16'hF800, 0);
    wait_done(0);
    check_frame(0);
    chk("f0_pixel", pix[0][7][13], 16'hF800);
    chk("f0_idle", BUSY, 0);

    start_frame(2'd1, 16'($urandom), 0);
    wait_done(1);
    check_frame(1);
    chk("bar_px0", pix[1][0][0], 16'h0000);
    chk("bar_px1", pix[1][0][BW], 16'h001F);
    chk("bar_px2", pix[1][0][2 * BW], 16'h07E0);
    chk("bar_px3", pix[1][5][3 * BW], 16'h07FF);
    chk("bar_last", pix[1][0][W - 1], 16'hFFFF);

    start_frame(2'd2, 16'h1234, 1);
    for (int i = 0; i < 4 * F && !(open && cur == 2 && c_lines >= 5); i++)
      @(negedge CLOCK);
    chk("f2_reach_line5", c_lines >= 5, 1);
    c = 16'($urandom);
    PATTERN = 2'd0;
    COLOR   = c;
    wait_done(2);
    chk("b2b_busy", BUSY, 1);
    check_frame(2);
    chk("stripe_l0", pix[0][0][17], 16'hF800);
    chk("stripe_l1", pix[0][1][3], 16'h0000);
    chk("stripe_l9", pix[0][9][30], 16'h0000);
    chk("stripe_l10", pix[0][10][0], 16'hF800);
    chk("stripe_l20", pix[0][20][W - 1], 16'hF800);

    for (int i = 0; i < 4 * F && !(open && cur == 3 && c_lines >= 10); i++)
      @(negedge CLOCK);
    chk("f3_reach_line10", c_lines >= 10, 1);
    ENABLE = 1'b0;
    wait_done(3);
    check_frame(3);
    chk("f3_new_color", pix[1][3][3], c);
    repeat (6 * L) @(negedge CLOCK);
    chk("no_more_vsync", nf, 4);
    chk("stop_busy", BUSY, 0);

    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? 2'd3 : 2'($urandom_range(0, 3));
      start_frame(p, 16'($urandom), 0);
      wait_done(4 + i);
      check_frame(4 + i);
    end
    chk("ramp_px", pix[0][13][21], ref_pix(2'd3, 16'h0, 21, 13));

    start_frame(2'd3, 16'h0, 0);
    for (int i = 0; i < 4 * F && !HREF; i++) @(negedge CLOCK);
    chk("rst_reach_active", HREF, 1);
    @(posedge CLOCK);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("midframe_reset", {P_CLOCK, VSYNC, HREF, DATA, BUSY, FRAME_DONE}, 0);
    repeat (3) @(negedge CLOCK);
    RESET_N = 1'b1;
    check_release("rel2");

    start_frame(2'd1, 16'h0, 0);
    wait_done(7);
    check_frame(7);

    chk("stable_at_rise", unstable, 0);
    chk("data_idle_zero", dz, 0);
    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
